// File: rtl/seven_seg_display_ctrl.sv
// Multi-field 7-segment controller: sequential double-dabble conversion per field, tear-free update, "End" message.
// Optional End-message blinking is compiled in with `define SEVSEG_END_BLINK_EN.
module seven_seg_display_ctrl #(
  parameter int                        NUM_FIELDS = 2,
  parameter int                        BIN_W      = 8,
  parameter logic [NUM_FIELDS*8-1:0]   REV_MAX    = {8'd99, 8'd59},
  parameter int                        BLINK_DIV  = 25000000
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          load_i,
  input  logic [NUM_FIELDS*BIN_W-1:0]   values_i,
  input  logic                          mode_sel_i,
  input  logic                          disp_end_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NUM_FIELDS*14-1:0]      hex_o
);

  localparam int FW   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int SC_W = $clog2(BIN_W) + 1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  if (BIN_W < 4 || BIN_W > 16) begin : g_bad_bin_w
    $error("seven_seg_display_ctrl: BIN_W must be within 4..16");
  end
  if (NUM_FIELDS < 1 || BLINK_DIV < 1) begin : g_bad_cfg
    $error("seven_seg_display_ctrl: NUM_FIELDS and BLINK_DIV must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_SHIFT,
    S_STORE,
    S_UPDATE
  } state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_e                          state_q;
  logic                            busy_q;
  logic                            done_q;
  logic [NUM_FIELDS*BIN_W-1:0]     values_q;
  logic                            mode_q;
  logic [FW-1:0]                   field_q;
  logic [SC_W-1:0]                 bit_cnt_q;
  logic [BIN_W-1:0]                op_q;
  logic [7:0]                      bcd_q;
  logic [NUM_FIELDS*8-1:0]         pend_q;

  logic [BIN_W-1:0]                cur_val;
  logic [7:0]                      cur_rev;
  logic [BIN_W-1:0]                operand_d;
  logic [7:0]                      bcd_adj;

  always_comb begin
    cur_val   = values_q[field_q*BIN_W +: BIN_W];
    cur_rev   = REV_MAX[field_q*8 +: 8];
    operand_d = '0;
    if (!mode_q) begin
      operand_d = (32'(cur_val) > 32'd99) ? BIN_W'(99) : cur_val;
    end else if (32'(cur_val) > 32'(cur_rev)) begin
      operand_d = '0;
    end else begin
      operand_d = BIN_W'(32'(cur_rev) - 32'(cur_val));
    end
  end

  // add-3 correction applied before every left shift of the BCD accumulator
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      values_q  <= '0;
      mode_q    <= 1'b0;
      field_q   <= '0;
      bit_cnt_q <= '0;
      op_q      <= '0;
      bcd_q     <= '0;
      pend_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_i) begin
            values_q <= values_i;
            mode_q   <= mode_sel_i;
            field_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_PREP;
          end
        end
        S_PREP: begin
          op_q      <= operand_d;
          bcd_q     <= '0;
          bit_cnt_q <= '0;
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_q     <= (bcd_adj << 1) | 8'(op_q[BIN_W-1]);
          op_q      <= op_q << 1;
          bit_cnt_q <= bit_cnt_q + SC_W'(1);
          if (bit_cnt_q == SC_W'(BIN_W - 1)) state_q <= S_STORE;
        end
        S_STORE: begin
          pend_q[field_q*8 +: 8] <= bcd_q;
          if (field_q == FW'(NUM_FIELDS - 1)) begin
            state_q <= S_UPDATE;
          end else begin
            field_q <= field_q + FW'(1);
            state_q <= S_PREP;
          end
        end
        S_UPDATE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [NUM_FIELDS*14-1:0] pend_seg;
  logic [NUM_FIELDS*14-1:0] end_msg;

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    assign pend_seg[gi*14+7 +: 7] = seg_encode(pend_q[gi*8+4 +: 4]);
    assign pend_seg[gi*14   +: 7] = seg_encode(pend_q[gi*8   +: 4]);
    if (NUM_FIELDS == 1) begin : g_msg_single
      assign end_msg[gi*14 +: 14] = {7'b0000110, 7'b0101011};
    end else if (gi == 1) begin : g_msg_en
      assign end_msg[gi*14 +: 14] = {7'b0000110, 7'b0101011};
    end else if (gi == 0) begin : g_msg_d
      assign end_msg[gi*14 +: 14] = {7'b0100001, SEG_BLANK};
    end else begin : g_msg_blank
      assign end_msg[gi*14 +: 14] = {SEG_BLANK, SEG_BLANK};
    end
  end

  logic                     disp_end_q;
  logic [NUM_FIELDS*14-1:0] shadow_q;
  logic                     msg_hidden;

  // shadow digits change only in UPDATE so every field flips on the same edge
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      disp_end_q <= 1'b0;
      shadow_q   <= '1;
    end else begin
      disp_end_q <= disp_end_i;
      if (state_q == S_UPDATE) shadow_q <= pend_seg;
    end
  end

`ifdef SEVSEG_END_BLINK_EN
  logic [31:0] blink_cnt_q;
  logic        blink_phase_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || !disp_end_q) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == 32'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 32'd1;
    end
  end

  assign msg_hidden = blink_phase_q;
`else
  assign msg_hidden = 1'b0;
`endif

  assign hex_o  = disp_end_q ? (msg_hidden ? '1 : end_msg) : shadow_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed-vector bench for seven_seg_display_ctrl (two fields, 8-bit values, BLINK_DIV = 4).
module tb_seven_seg_display_ctrl;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        load     = 1'b0;
  logic [15:0] values   = '0;
  logic        mode_sel = 1'b0;
  logic        disp_end = 1'b0;
  logic        busy;
  logic        done;
  logic [27:0] hex;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [27:0] MSG   = {7'b0000110, 7'b0101011, 7'b0100001, 7'h7F};
  localparam logic [27:0] BLANK = 28'hFFF_FFFF;

  seven_seg_display_ctrl #(
    .NUM_FIELDS(2),
    .BIN_W     (8),
    .REV_MAX   ({8'd99, 8'd59}),
    .BLINK_DIV (4)
  ) u_dut (
    .clock_i   (clock),
    .reset_i   (reset),
    .load_i    (load),
    .values_i  (values),
    .mode_sel_i(mode_sel),
    .disp_end_i(disp_end),
    .busy_o    (busy),
    .done_o    (done),
    .hex_o     (hex)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] hex2(input int f1, input int f0);
    return {seg(f1 / 10), seg(f1 % 10), seg(f0 / 10), seg(f0 % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // load at edge k, expect busy k..k+20, done and new digits at k+21
  task automatic run_conv(input int v1, input int v0, input logic m,
                          input int e1, input int e0, input string tag);
    int nbusy;
    int ndone;
    values   = {8'(v1), 8'(v0)};
    mode_sel = m;
    load     = 1'b1;
    step();
    load  = 1'b0;
    nbusy = 0;
    ndone = 0;
    if (busy) nbusy++;
    if (done) ndone++;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (busy) nbusy++;
      if (done) ndone++;
    end
    check_eq({tag, "_busy_cycles"}, nbusy, 21);
    check_eq({tag, "_early_done"}, ndone, 0);
    step();
    check_eq({tag, "_done"}, 32'(done), 1);
    check_eq({tag, "_busy_low"}, 32'(busy), 0);
    check_eq({tag, "_hex"}, 32'(hex), 32'(hex2(e1, e0)));
    step();
    check_eq({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int nd;
    int first_done;
    int second_done;
    logic [27:0] exp_hex;

    // reset with load held high
    load   = 1'b1;
    values = 16'h1234;
    repeat (3) step();
    check_eq("reset_hex", 32'(hex), 32'(BLANK));
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_done", 32'(done), 0);
    reset = 1'b0;
    load  = 1'b0;
    step();
    check_eq("reset_load_ignored", 32'(busy), 0);

    run_conv(1, 23, 1'b0, 1, 23, "direct_01_23");
    run_conv(0, 17, 1'b1, 99, 42, "rev_99_42");
    run_conv(0, 60, 1'b1, 99, 0, "rev_over_limit");
    run_conv(99, 59, 1'b1, 0, 0, "rev_at_limit");
    run_conv(50, 5, 1'b1, 49, 54, "rev_49_54");
    run_conv(200, 150, 1'b0, 99, 99, "direct_clamp");
    run_conv(7, 0, 1'b0, 7, 0, "leading_zeros");

    // loads at k+5 and k+21 are dropped, load at k+22 is taken
    nd = 0;
    first_done = -1;
    second_done = -1;
    for (int c = 0; c <= 44; c++) begin
      values   = (c < 5) ? {8'd3, 8'd45} : (c < 22) ? {8'd7, 8'd89} : {8'd6, 8'd78};
      mode_sel = 1'b0;
      load     = (c == 0 || c == 5 || c == 21 || c == 22);
      step();
      if (done) begin
        nd++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (c == 21) check_eq("ignore_first_hex", 32'(hex), 32'(hex2(3, 45)));
      if (c == 43) check_eq("ignore_second_hex", 32'(hex), 32'(hex2(6, 78)));
    end
    load = 1'b0;
    check_eq("ignore_done_count", nd, 2);
    check_eq("ignore_first_done_cycle", first_done, 21);
    check_eq("ignore_second_done_cycle", second_done, 43);

    // reset at k+10 aborts the conversion
    nd = 0;
    for (int c = 0; c <= 30; c++) begin
      values   = {8'd12, 8'd34};
      mode_sel = 1'b0;
      load     = (c == 0);
      reset    = (c == 10);
      step();
      if (done) nd++;
      if (c == 10) begin
        check_eq("abort_hex_blank", 32'(hex), 32'(BLANK));
        check_eq("abort_busy_low", 32'(busy), 0);
      end
    end
    reset = 1'b0;
    load  = 1'b0;
    check_eq("abort_no_done", nd, 0);
    check_eq("abort_hex_stays_blank", 32'(hex), 32'(BLANK));
    run_conv(12, 34, 1'b0, 12, 34, "after_abort");

    // End message, with a conversion running underneath
    disp_end = 1'b1;
    values   = {8'd56, 8'd9};
    mode_sel = 1'b0;
    load     = 1'b1;
    step();
    load = 1'b0;
    nd = 0;
    for (int j = 0; j <= 21; j++) begin
      if (j > 0) step();
      if (done) nd++;
      exp_hex = MSG;
`ifdef SEVSEG_END_BLINK_EN
      if (((j / 4) % 2) == 1) exp_hex = BLANK;
`endif
      check_eq("end_msg", 32'(hex), 32'(exp_hex));
    end
    check_eq("end_conv_done_count", nd, 1);
    disp_end = 1'b0;
    step();
    check_eq("end_release_digits", 32'(hex), 32'(hex2(56, 9)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
- Parametrised, sequential successor to the timer's two-field 7-seg encoder.
- Drives NUM_FIELDS two-digit fields, each fed by a BIN_W binary value.
- Each field has its own count-down reversal limit. Binary-to-BCD conversion is iterative (shift-add-3), one field at a time, with a load/busy/done handshake.
- Sits between the timer counter core and the HEX pins. All outputs are registered, and the "End" message path is registered.

Parameters:
- NUM_FIELDS, 2: number of two-digit fields. Field 0 is the least significant, on the rightmost displays.
- BIN_W, 8: width of each binary field input, 4..16.
- REV_MAX, {8'd99, 8'd59}: packed NUM_FIELDS x 8 bits. Byte f is the reversal limit of field f, 0..99.
- BLINK_DIV, 25000000: clock cycles per half-period of the End blink. Used only when the optional feature is compiled in.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: one-cycle strobe; capture values and mode_sel.
- values, input, NUM_FIELDS*BIN_W: field f occupies [f*BIN_W +: BIN_W].
- mode_sel, input, 1: 1 = count-down display (reversed); 0 = direct display.
- disp_end, input, 1: level; show the End message.
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: one-cycle pulse when the hex outputs update.
- hex, output, NUM_FIELDS*14: active-low segments, bit0 = a through bit6 = g. Field f tens digit is at [f*14+7 +: 7] and its ones digit at [f*14 +: 7].

Behaviour:
- Reset sets:
  - state = IDLE, busy = 0, done = 0;
  - all shadow digit registers = blank (7'h7F), so hex = all 7'h7F;
  - disp_end register = 0;
  - blink counter = 0, blink phase = visible.
- Reset mid-conversion aborts the conversion; no done pulse is produced.
- Load is accepted only in IDLE. A load while busy = 1 is ignored and not queued.
- On an accepted load at edge k:
  - values and mode_sel are captured;
  - busy = 1 from edge k;
  - the FSM walks field 0 up to field NUM_FIELDS-1.
- Per field, the FSM spends BIN_W+2 cycles:
  - PREP, 1 cycle: compute the operand v.
    - If mode_sel = 0, v = min(value, 99).
    - If mode_sel = 1 and value > REV_MAX_f, v = 0.
    - Otherwise (mode_sel = 1), v = REV_MAX_f - value.
    - Arithmetic is BIN_W bits wide, with no wrap.
  - SHIFT, BIN_W cycles: double-dabble. Any BCD nibble >= 5 gets +3 before each left shift. An 8-bit BCD accumulator is sufficient because v <= 99.
  - STORE, 1 cycle: write the tens/ones nibbles to the pending buffer for field f.
- After the last STORE, the FSM enters UPDATE, 1 cycle:
  - pending is copied into the shadow digit registers for all fields at once, so fields never tear;
  - done = 1 for that cycle;
  - busy drops to 0 on the same edge;
  - the FSM returns to IDLE.
- Latency: hex changes on edge k + NUM_FIELDS*(BIN_W+2) + 1. With the defaults this is k+21.
  - A new load is accepted in the cycle after done.
  - If load arrives in the same cycle as UPDATE, it is ignored.
- Digit encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading zeros are shown, not blanked.
- disp_end is registered (1-cycle latency). While the registered value is 1, hex shows the message instead of the shadow digits:
  - field 1 tens = E (0000110);
  - field 1 ones = n (0101011);
  - field 0 tens = d (0100001);
  - field 0 ones = blank;
  - fields >= 2 = blank.
- Conversions continue underneath the message. The shadow digits reappear the cycle after the registered disp_end falls.
- If NUM_FIELDS = 1, the field 0 message is "En".

Optional Feature:
- Macro: SEVSEG_END_BLINK_EN.
- Defined:
  - while the registered disp_end = 1, a counter toggles the blink phase every BLINK_DIV cycles;
  - the message is shown in the visible phase and all-blank in the other;
  - the counter and phase reset to 0/visible whenever the registered disp_end = 0 or reset = 1.
- Undefined: no counter is present and the message is steady.

Test Plan:
- Reset held 3 cycles with load=1 -> hex = all 7'h7F, busy=0, done=0; load is ignored.
- Defaults, values={8'd1, 8'd23}, mode_sel=0, load at edge k -> busy high k..k+20. At k+21 done=1 and hex = "01" "23", field 0 = 0100100 / 0110000.
- mode_sel=1, values={8'd0, 8'd17} -> field 0 shows 42 (59-17) and field 1 shows 99 (99-0). A value of 60 in field 0 -> 00.
- Load pulsed again at k+5 and k+21 -> both are ignored, with exactly one done pulse. A load at k+22 starts a new conversion.
- Reset asserted at k+10 mid-conversion -> no done pulse, hex blank, and a following load converts normally.
- disp_end=1 -> next cycle hex = E,n,d,blank. With SEVSEG_END_BLINK_EN and BLINK_DIV=4, the message toggles to blank every 4 cycles. On deassert, the digits return the next cycle.
